// File: rtl/fight_pkg.sv
// Shared fight-engine constants and the packed hurtbox slice helper.
package fight_pkg;

   localparam int COORD_W          = 10;
   localparam int NUM_HURT         = 2;
   localparam int HITSTUN_FRAMES   = 12;
   localparam int BLOCKSTUN_FRAMES = 6;
   localparam int CNT_W            = 5;

   function automatic int box_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/hit_channel.sv
// One attack direction: attacker hitbox vs victim hurtboxes, single-connect
// latch, registered hit/block pulses and the victim's stun counter.
module hit_channel #(
   parameter int COORD_W          = fight_pkg::COORD_W,
   parameter int NUM_HURT         = fight_pkg::NUM_HURT,
   parameter int HITSTUN_FRAMES   = fight_pkg::HITSTUN_FRAMES,
   parameter int BLOCKSTUN_FRAMES = fight_pkg::BLOCKSTUN_FRAMES,
   parameter int CNT_W            = fight_pkg::CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_frame_tick,
   input  logic [COORD_W-1:0]          i_hb_x1,
   input  logic [COORD_W-1:0]          i_hb_x2,
   input  logic [COORD_W-1:0]          i_hb_y1,
   input  logic [COORD_W-1:0]          i_hb_y2,
   input  logic                        i_hb_active,
   input  logic                        i_attack_flag,
   input  logic                        i_dir_attack_flag,
   input  logic                        i_attack_start,
   input  logic [NUM_HURT*COORD_W-1:0] i_hu_x1,
   input  logic [NUM_HURT*COORD_W-1:0] i_hu_x2,
   input  logic [NUM_HURT*COORD_W-1:0] i_hu_y1,
   input  logic [NUM_HURT*COORD_W-1:0] i_hu_y2,
   input  logic [NUM_HURT-1:0]         i_hu_active,
   input  logic                        i_is_blocking,
   output logic                        o_got_hit,
   output logic                        o_got_blocked,
   output logic                        o_stun,
   output logic                        o_hitstun,
   output logic [CNT_W-1:0]            o_stun_cnt
);
   import fight_pkg::*;

   localparam logic [CNT_W-1:0] HIT_LOAD = CNT_W'(HITSTUN_FRAMES);
   localparam logic [CNT_W-1:0] BLK_LOAD = CNT_W'(BLOCKSTUN_FRAMES);

   logic [NUM_HURT-1:0] w_box_hit;
   logic                w_overlap_any;
   logic                w_connected_eff;
   logic                w_hit_cond;
   logic                w_block_cond;

   logic                r_connected;
   logic                r_got_hit;
   logic                r_got_blocked;
   logic                r_hitstun;
   logic [CNT_W-1:0]    r_stun_cnt;

   // Inverted x extents are rejected explicitly; strict compares alone would accept them.
   always_comb begin
      w_box_hit = '0;
      for (int k = 0; k < NUM_HURT; k++) begin
         w_box_hit[k] = i_hu_active[k]
            && (i_hb_x1 < i_hb_x2)
            && (i_hu_x1[box_lsb(k, COORD_W) +: COORD_W] < i_hu_x2[box_lsb(k, COORD_W) +: COORD_W])
            && (i_hb_x1 < i_hu_x2[box_lsb(k, COORD_W) +: COORD_W])
            && (i_hb_x2 > i_hu_x1[box_lsb(k, COORD_W) +: COORD_W])
            && (i_hb_y1 < i_hu_y2[box_lsb(k, COORD_W) +: COORD_W])
            && (i_hb_y2 > i_hu_y1[box_lsb(k, COORD_W) +: COORD_W]);
      end
   end

   assign w_overlap_any   = i_hb_active && (|w_box_hit);
   assign w_connected_eff = r_connected && !i_attack_start;
   assign w_hit_cond      = w_overlap_any && i_attack_flag && !i_is_blocking && !w_connected_eff;
   assign w_block_cond    = w_overlap_any && i_dir_attack_flag && i_is_blocking && !w_connected_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_connected   <= 1'b0;
         r_got_hit     <= 1'b0;
         r_got_blocked <= 1'b0;
         r_hitstun     <= 1'b0;
         r_stun_cnt    <= '0;
      end else begin
         r_got_hit     <= w_hit_cond;
         r_got_blocked <= w_block_cond;

         if (w_hit_cond || w_block_cond)
            r_connected <= 1'b1;
         else if (i_attack_start)
            r_connected <= 1'b0;

         // A fresh load always beats a coincident frame decrement.
         if (w_hit_cond) begin
            r_stun_cnt <= HIT_LOAD;
            r_hitstun  <= 1'b1;
         end else if (w_block_cond) begin
            r_stun_cnt <= BLK_LOAD;
            r_hitstun  <= 1'b0;
         end else if (i_frame_tick && (r_stun_cnt != '0)) begin
            r_stun_cnt <= r_stun_cnt - CNT_W'(1);
            if (r_stun_cnt == CNT_W'(1))
               r_hitstun <= 1'b0;
         end
      end
   end

   assign o_got_hit     = r_got_hit;
   assign o_got_blocked = r_got_blocked;
   assign o_stun        = (r_stun_cnt != '0);
   assign o_hitstun     = r_hitstun;
   assign o_stun_cnt    = r_stun_cnt;

endmodule

// File: rtl/hit_resolver.sv
// Symmetric hit/block resolver: two hit_channel instances with the
// attacker and victim roles crossed between the players.
module hit_resolver #(
   parameter int COORD_W          = fight_pkg::COORD_W,
   parameter int NUM_HURT         = fight_pkg::NUM_HURT,
   parameter int HITSTUN_FRAMES   = fight_pkg::HITSTUN_FRAMES,
   parameter int BLOCKSTUN_FRAMES = fight_pkg::BLOCKSTUN_FRAMES,
   parameter int CNT_W            = fight_pkg::CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_tick,
   input  logic [COORD_W-1:0]          hb_x1_p1,
   input  logic [COORD_W-1:0]          hb_x2_p1,
   input  logic [COORD_W-1:0]          hb_y1_p1,
   input  logic [COORD_W-1:0]          hb_y2_p1,
   input  logic                        hb_active_p1,
   input  logic                        attack_flag_p1,
   input  logic                        dir_attack_flag_p1,
   input  logic                        attack_start_p1,
   input  logic [COORD_W-1:0]          hb_x1_p2,
   input  logic [COORD_W-1:0]          hb_x2_p2,
   input  logic [COORD_W-1:0]          hb_y1_p2,
   input  logic [COORD_W-1:0]          hb_y2_p2,
   input  logic                        hb_active_p2,
   input  logic                        attack_flag_p2,
   input  logic                        dir_attack_flag_p2,
   input  logic                        attack_start_p2,
   input  logic [NUM_HURT*COORD_W-1:0] hu_x1_p1,
   input  logic [NUM_HURT*COORD_W-1:0] hu_x2_p1,
   input  logic [NUM_HURT*COORD_W-1:0] hu_y1_p1,
   input  logic [NUM_HURT*COORD_W-1:0] hu_y2_p1,
   input  logic [NUM_HURT-1:0]         hu_active_p1,
   input  logic [NUM_HURT*COORD_W-1:0] hu_x1_p2,
   input  logic [NUM_HURT*COORD_W-1:0] hu_x2_p2,
   input  logic [NUM_HURT*COORD_W-1:0] hu_y1_p2,
   input  logic [NUM_HURT*COORD_W-1:0] hu_y2_p2,
   input  logic [NUM_HURT-1:0]         hu_active_p2,
   input  logic                        is_blocking_p1,
   input  logic                        is_blocking_p2,
   output logic                        got_hit_p1,
   output logic                        got_blocked_p1,
   output logic                        stun_p1,
   output logic                        hitstun_p1,
   output logic [CNT_W-1:0]            stun_cnt_p1,
   output logic                        got_hit_p2,
   output logic                        got_blocked_p2,
   output logic                        stun_p2,
   output logic                        hitstun_p2,
   output logic [CNT_W-1:0]            stun_cnt_p2
);
   import fight_pkg::*;

   // P1 attacks, P2 is the victim.
   hit_channel #(
      .COORD_W(COORD_W), .NUM_HURT(NUM_HURT), .HITSTUN_FRAMES(HITSTUN_FRAMES),
      .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES), .CNT_W(CNT_W)
   ) u_p1_to_p2 (
      .clk(clk), .rst(rst), .i_frame_tick(frame_tick),
      .i_hb_x1(hb_x1_p1), .i_hb_x2(hb_x2_p1), .i_hb_y1(hb_y1_p1), .i_hb_y2(hb_y2_p1),
      .i_hb_active(hb_active_p1), .i_attack_flag(attack_flag_p1),
      .i_dir_attack_flag(dir_attack_flag_p1), .i_attack_start(attack_start_p1),
      .i_hu_x1(hu_x1_p2), .i_hu_x2(hu_x2_p2), .i_hu_y1(hu_y1_p2), .i_hu_y2(hu_y2_p2),
      .i_hu_active(hu_active_p2), .i_is_blocking(is_blocking_p2),
      .o_got_hit(got_hit_p2), .o_got_blocked(got_blocked_p2), .o_stun(stun_p2),
      .o_hitstun(hitstun_p2), .o_stun_cnt(stun_cnt_p2)
   );

   // P2 attacks, P1 is the victim.
   hit_channel #(
      .COORD_W(COORD_W), .NUM_HURT(NUM_HURT), .HITSTUN_FRAMES(HITSTUN_FRAMES),
      .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES), .CNT_W(CNT_W)
   ) u_p2_to_p1 (
      .clk(clk), .rst(rst), .i_frame_tick(frame_tick),
      .i_hb_x1(hb_x1_p2), .i_hb_x2(hb_x2_p2), .i_hb_y1(hb_y1_p2), .i_hb_y2(hb_y2_p2),
      .i_hb_active(hb_active_p2), .i_attack_flag(attack_flag_p2),
      .i_dir_attack_flag(dir_attack_flag_p2), .i_attack_start(attack_start_p2),
      .i_hu_x1(hu_x1_p1), .i_hu_x2(hu_x2_p1), .i_hu_y1(hu_y1_p1), .i_hu_y2(hu_y2_p1),
      .i_hu_active(hu_active_p1), .i_is_blocking(is_blocking_p1),
      .o_got_hit(got_hit_p1), .o_got_blocked(got_blocked_p1), .o_stun(stun_p1),
      .o_hitstun(hitstun_p1), .o_stun_cnt(stun_cnt_p1)
   );

endmodule

// File: tb/tb_hit_resolver.sv
// Directed self-checking bench for hit_resolver.
module tb_hit_resolver;

   localparam int CW = 10;
   localparam int NH = 2;
   localparam int KW = 5;

   logic clk = 1'b0;
   logic rst, frame_tick;
   logic [CW-1:0] hb_x1_p1, hb_x2_p1, hb_y1_p1, hb_y2_p1;
   logic [CW-1:0] hb_x1_p2, hb_x2_p2, hb_y1_p2, hb_y2_p2;
   logic hb_active_p1, attack_flag_p1, dir_attack_flag_p1, attack_start_p1;
   logic hb_active_p2, attack_flag_p2, dir_attack_flag_p2, attack_start_p2;
   logic [NH*CW-1:0] hu_x1_p1, hu_x2_p1, hu_y1_p1, hu_y2_p1;
   logic [NH*CW-1:0] hu_x1_p2, hu_x2_p2, hu_y1_p2, hu_y2_p2;
   logic [NH-1:0] hu_active_p1, hu_active_p2;
   logic is_blocking_p1, is_blocking_p2;
   logic got_hit_p1, got_blocked_p1, stun_p1, hitstun_p1;
   logic got_hit_p2, got_blocked_p2, stun_p2, hitstun_p2;
   logic [KW-1:0] stun_cnt_p1, stun_cnt_p2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hit_resolver dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .hb_x1_p1(hb_x1_p1), .hb_x2_p1(hb_x2_p1), .hb_y1_p1(hb_y1_p1), .hb_y2_p1(hb_y2_p1),
      .hb_active_p1(hb_active_p1), .attack_flag_p1(attack_flag_p1),
      .dir_attack_flag_p1(dir_attack_flag_p1), .attack_start_p1(attack_start_p1),
      .hb_x1_p2(hb_x1_p2), .hb_x2_p2(hb_x2_p2), .hb_y1_p2(hb_y1_p2), .hb_y2_p2(hb_y2_p2),
      .hb_active_p2(hb_active_p2), .attack_flag_p2(attack_flag_p2),
      .dir_attack_flag_p2(dir_attack_flag_p2), .attack_start_p2(attack_start_p2),
      .hu_x1_p1(hu_x1_p1), .hu_x2_p1(hu_x2_p1), .hu_y1_p1(hu_y1_p1), .hu_y2_p1(hu_y2_p1),
      .hu_active_p1(hu_active_p1),
      .hu_x1_p2(hu_x1_p2), .hu_x2_p2(hu_x2_p2), .hu_y1_p2(hu_y1_p2), .hu_y2_p2(hu_y2_p2),
      .hu_active_p2(hu_active_p2),
      .is_blocking_p1(is_blocking_p1), .is_blocking_p2(is_blocking_p2),
      .got_hit_p1(got_hit_p1), .got_blocked_p1(got_blocked_p1), .stun_p1(stun_p1),
      .hitstun_p1(hitstun_p1), .stun_cnt_p1(stun_cnt_p1),
      .got_hit_p2(got_hit_p2), .got_blocked_p2(got_blocked_p2), .stun_p2(stun_p2),
      .hitstun_p2(hitstun_p2), .stun_cnt_p2(stun_cnt_p2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      frame_tick = 0;
      hb_x1_p1 = 0; hb_x2_p1 = 0; hb_y1_p1 = 0; hb_y2_p1 = 0;
      hb_x1_p2 = 0; hb_x2_p2 = 0; hb_y1_p2 = 0; hb_y2_p2 = 0;
      hb_active_p1 = 0; attack_flag_p1 = 0; dir_attack_flag_p1 = 0; attack_start_p1 = 0;
      hb_active_p2 = 0; attack_flag_p2 = 0; dir_attack_flag_p2 = 0; attack_start_p2 = 0;
      hu_x1_p1 = 0; hu_x2_p1 = 0; hu_y1_p1 = 0; hu_y2_p1 = 0; hu_active_p1 = 0;
      hu_x1_p2 = 0; hu_x2_p2 = 0; hu_y1_p2 = 0; hu_y2_p2 = 0; hu_active_p2 = 0;
      is_blocking_p1 = 0; is_blocking_p2 = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   // P1 hitbox (100,150,200,260) vs P2 hurtbox0 (140,180,180,300); box1 parked far away.
   task automatic std_geometry();
      hb_x1_p1 = 100; hb_x2_p1 = 150; hb_y1_p1 = 200; hb_y2_p1 = 260; hb_active_p1 = 1;
      hu_x1_p2 = {10'd500, 10'd140}; hu_x2_p2 = {10'd520, 10'd180};
      hu_y1_p2 = {10'd0, 10'd180};   hu_y2_p2 = {10'd20, 10'd300};
      hu_active_p2 = 2'b01;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (got_hit_p1 !== 1'b0 || got_hit_p2 !== 1'b0) begin
         errors++; $display("FAIL reset_got_hit: got %b%b expected 00", got_hit_p1, got_hit_p2); end
      checks++; if (got_blocked_p1 !== 1'b0 || got_blocked_p2 !== 1'b0) begin
         errors++; $display("FAIL reset_got_blocked: got %b%b expected 00", got_blocked_p1, got_blocked_p2); end
      checks++; if (stun_cnt_p1 !== 5'd0 || stun_cnt_p2 !== 5'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stun_cnt_p1, stun_cnt_p2); end
      checks++; if (stun_p1 !== 1'b0 || stun_p2 !== 1'b0 || hitstun_p1 !== 1'b0 || hitstun_p2 !== 1'b0) begin
         errors++; $display("FAIL reset_stun: got %b%b%b%b expected 0000", stun_p1, stun_p2, hitstun_p1, hitstun_p2); end
   endtask

   task automatic test_hit();
      do_reset();
      std_geometry();
      attack_flag_p1 = 1;
      step();
      checks++; if (got_hit_p2 !== 1'b1) begin
         errors++; $display("FAIL hit_pulse: got %b expected 1", got_hit_p2); end
      checks++; if (stun_cnt_p2 !== 5'd12 || hitstun_p2 !== 1'b1 || stun_p2 !== 1'b1) begin
         errors++; $display("FAIL hit_load: cnt %0d hitstun %b stun %b expected 12 1 1", stun_cnt_p2, hitstun_p2, stun_p2); end
      checks++; if (got_hit_p1 !== 1'b0 || stun_cnt_p1 !== 5'd0) begin
         errors++; $display("FAIL hit_p1_idle: got %b cnt %0d expected 0 0", got_hit_p1, stun_cnt_p1); end
      hb_active_p1 = 0;
      step();
      checks++; if (got_hit_p2 !== 1'b0) begin
         errors++; $display("FAIL hit_single_pulse: got %b expected 0", got_hit_p2); end
      frame_tick = 1;
      for (int i = 0; i < 11; i++) step();
      checks++; if (stun_cnt_p2 !== 5'd1 || stun_p2 !== 1'b1 || hitstun_p2 !== 1'b1) begin
         errors++; $display("FAIL hit_decay11: cnt %0d stun %b hitstun %b expected 1 1 1", stun_cnt_p2, stun_p2, hitstun_p2); end
      step();
      checks++; if (stun_cnt_p2 !== 5'd0 || stun_p2 !== 1'b0 || hitstun_p2 !== 1'b0) begin
         errors++; $display("FAIL hit_decay12: cnt %0d stun %b hitstun %b expected 0 0 0", stun_cnt_p2, stun_p2, hitstun_p2); end
      step();
      checks++; if (stun_cnt_p2 !== 5'd0) begin
         errors++; $display("FAIL hit_saturate: cnt %0d expected 0", stun_cnt_p2); end
      frame_tick = 0;
   endtask

   task automatic test_block();
      // Hitting but not directional, victim guarding: neither hit nor block.
      do_reset();
      std_geometry();
      attack_flag_p1 = 1; is_blocking_p2 = 1;
      step();
      checks++; if (got_hit_p2 !== 1'b0 || got_blocked_p2 !== 1'b0 || stun_cnt_p2 !== 5'd0) begin
         errors++; $display("FAIL block_nodir: hit %b blk %b cnt %0d expected 0 0 0", got_hit_p2, got_blocked_p2, stun_cnt_p2); end
      // Both flags set, victim guarding: block.
      dir_attack_flag_p1 = 1;
      step();
      checks++; if (got_blocked_p2 !== 1'b1 || got_hit_p2 !== 1'b0) begin
         errors++; $display("FAIL block_pulse: blk %b hit %b expected 1 0", got_blocked_p2, got_hit_p2); end
      checks++; if (stun_cnt_p2 !== 5'd6 || hitstun_p2 !== 1'b0 || stun_p2 !== 1'b1) begin
         errors++; $display("FAIL block_load: cnt %0d hitstun %b stun %b expected 6 0 1", stun_cnt_p2, hitstun_p2, stun_p2); end
      step();
      checks++; if (got_blocked_p2 !== 1'b0 || got_hit_p2 !== 1'b0) begin
         errors++; $display("FAIL block_single: blk %b hit %b expected 0 0", got_blocked_p2, got_hit_p2); end
   endtask

   task automatic test_connect_once();
      int pulses;
      do_reset();
      std_geometry();
      attack_flag_p1 = 1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (got_hit_p2 === 1'b1) pulses++;
      end
      checks++; if (pulses !== 1) begin
         errors++; $display("FAIL connect_once: got %0d pulses expected 1", pulses); end
      frame_tick = 1;
      for (int i = 0; i < 5; i++) step();
      checks++; if (stun_cnt_p2 !== 5'd7) begin
         errors++; $display("FAIL connect_decay: cnt %0d expected 7", stun_cnt_p2); end
      // Re-arm with a coincident frame tick: the load must win.
      attack_start_p1 = 1;
      step();
      attack_start_p1 = 0;
      frame_tick = 0;
      checks++; if (got_hit_p2 !== 1'b1 || stun_cnt_p2 !== 5'd12) begin
         errors++; $display("FAIL connect_rearm: hit %b cnt %0d expected 1 12", got_hit_p2, stun_cnt_p2); end
      step();
      checks++; if (got_hit_p2 !== 1'b0) begin
         errors++; $display("FAIL connect_after_rearm: hit %b expected 0", got_hit_p2); end
   endtask

   task automatic test_edges();
      do_reset();
      std_geometry();
      attack_flag_p1 = 1;
      hb_x2_p1 = 140;
      step(); step();
      checks++; if (got_hit_p2 !== 1'b0 || stun_cnt_p2 !== 5'd0) begin
         errors++; $display("FAIL edge_touch: hit %b cnt %0d expected 0 0", got_hit_p2, stun_cnt_p2); end
      // Inverted hitbox extent lies inside the hurtbox span but must not connect.
      hb_x1_p1 = 150; hb_x2_p1 = 145;
      hu_x1_p2 = {10'd500, 10'd100}; hu_x2_p2 = {10'd520, 10'd200};
      step(); step();
      checks++; if (got_hit_p2 !== 1'b0 || stun_cnt_p2 !== 5'd0) begin
         errors++; $display("FAIL edge_inverted: hit %b cnt %0d expected 0 0", got_hit_p2, stun_cnt_p2); end
      // Only hurtbox1 overlaps; box0 parked away.
      hb_x1_p1 = 100; hb_x2_p1 = 150;
      hu_x1_p2 = {10'd140, 10'd300}; hu_x2_p2 = {10'd180, 10'd400};
      hu_y1_p2 = {10'd180, 10'd180}; hu_y2_p2 = {10'd300, 10'd300};
      hu_active_p2 = 2'b00;
      step(); step();
      checks++; if (got_hit_p2 !== 1'b0 || stun_cnt_p2 !== 5'd0) begin
         errors++; $display("FAIL edge_box1_inactive: hit %b cnt %0d expected 0 0", got_hit_p2, stun_cnt_p2); end
      hu_active_p2 = 2'b10;
      step();
      checks++; if (got_hit_p2 !== 1'b1 || stun_cnt_p2 !== 5'd12) begin
         errors++; $display("FAIL edge_box1_active: hit %b cnt %0d expected 1 12", got_hit_p2, stun_cnt_p2); end
   endtask

   task automatic test_trade();
      do_reset();
      std_geometry();
      attack_flag_p1 = 1;
      hb_x1_p2 = 300; hb_x2_p2 = 360; hb_y1_p2 = 100; hb_y2_p2 = 160; hb_active_p2 = 1;
      hu_x1_p1 = {10'd0, 10'd340}; hu_x2_p1 = {10'd10, 10'd400};
      hu_y1_p1 = {10'd0, 10'd120}; hu_y2_p1 = {10'd10, 10'd200};
      hu_active_p1 = 2'b01; attack_flag_p2 = 1;
      step();
      checks++; if (got_hit_p1 !== 1'b1 || got_hit_p2 !== 1'b1) begin
         errors++; $display("FAIL trade_pulses: p1 %b p2 %b expected 1 1", got_hit_p1, got_hit_p2); end
      checks++; if (stun_cnt_p1 !== 5'd12 || stun_cnt_p2 !== 5'd12 || hitstun_p1 !== 1'b1) begin
         errors++; $display("FAIL trade_cnt: p1 %0d p2 %0d hs1 %b expected 12 12 1", stun_cnt_p1, stun_cnt_p2, hitstun_p1); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      std_geometry();
      attack_flag_p1 = 1;
      step();
      frame_tick = 1;
      for (int i = 0; i < 3; i++) step();
      frame_tick = 0;
      checks++; if (stun_cnt_p2 !== 5'd9) begin
         errors++; $display("FAIL midrst_pre: cnt %0d expected 9", stun_cnt_p2); end
      rst = 1;
      step();
      rst = 0;
      checks++; if (stun_cnt_p2 !== 5'd0 || stun_p2 !== 1'b0 || hitstun_p2 !== 1'b0 || got_hit_p2 !== 1'b0) begin
         errors++; $display("FAIL midrst_clear: cnt %0d stun %b hs %b hit %b expected 0 0 0 0", stun_cnt_p2, stun_p2, hitstun_p2, got_hit_p2); end
      step();
      checks++; if (got_hit_p2 !== 1'b1 || stun_cnt_p2 !== 5'd12) begin
         errors++; $display("FAIL midrst_rehit: hit %b cnt %0d expected 1 12", got_hit_p2, stun_cnt_p2); end
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_hit();
      test_block();
      test_connect_once();
      test_edges();
      test_trade();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
